mfcc_framer: RTL
================

Name: mfcc_framer

Overview:
- Parametrised framing stage at the head of the MFCC front end. It sits between the sample source (RAM reader or ADC stream) and the windowing/FFT stage.
- Accepts a valid/ready sample stream and optionally decimates it by 2 (fs mode select).
- Stores samples in a circular buffer and emits overlapping frames of FRAME_LEN samples advanced by HOP samples, each with last-sample and frame-index tags.
- Supersedes the fixed 256/128 framing with configurable width, length, hop, frame count and rate mode.

Parameters:
- DATA_W, 16, sample width in bits.
- FRAME_LEN, 256, samples per frame. Power of two, >= 4.
- HOP, 128, frame advance in samples. 1 <= HOP <= FRAME_LEN.
- NUM_FRAMES, 0, frames per run. 0 = run until start re-issued or reset.
- FIDX_W, 16, frame index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse: clear buffer and begin a run.
- fs_control  in  1  1 = full rate; 0 = decimate by 2 (keep even-phase samples). Sampled at start only.
- in_data  in  DATA_W  input sample, signed.
- in_valid  in  1  input sample valid.
- in_ready  out  1  framer can accept a sample.
- out_data  out  DATA_W  frame sample.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_last  out  1  last sample of current frame.
- frame_idx  out  FIDX_W  index of frame being emitted, 0-based.
- fefinish  out  1  one-cycle pulse after the last sample of frame NUM_FRAMES-1.
- busy  out  1  run in progress.

Behaviour:
- Reset: in_ready=0, out_valid=0, out_last=0, out_data=0, frame_idx=0, fefinish=0, busy=0. State=IDLE. All pointers and the decimation phase are cleared. Reset mid-run aborts immediately; no partial frame is emitted after release.
- Buffer:
  - Circular, depth 2*FRAME_LEN.
  - Pointers wr_ptr, base, rd_off use log2(2*FRAME_LEN)+1 bits and wrap modulo 2*FRAME_LEN.
  - occupancy = wr_ptr - base.
- States IDLE -> RUN, and RUN -> IDLE on fefinish.
  - IDLE: in_ready=0. A start pulse clears the pointers, latches the fs_control mode, sets busy=1, clears frame_idx and enters RUN.
  - start while in RUN restarts the run identically; the in-flight frame is discarded and out_valid drops the next cycle.
- Input handshake (RUN only):
  - in_ready = (occupancy < 2*FRAME_LEN).
  - A transfer occurs when in_valid && in_ready.
  - Mode full rate: every transfer writes the sample and increments wr_ptr.
  - Mode decimate: the phase toggles on each transfer. Only phase-0 transfers write; phase-1 transfers are consumed and dropped.
- Output emission:
  - A frame is eligible when occupancy >= FRAME_LEN.
  - Samples are emitted in order from buffer[base+rd_off], rd_off = 0..FRAME_LEN-1.
  - out_data/out_valid are registered. Latency from eligibility (or from the previous accepted output) to out_valid is 1 cycle, so the sustained rate is 1 sample/clk while out_ready=1.
  - The output is held stable while out_valid && !out_ready.
  - out_last=1 with rd_off=FRAME_LEN-1.
  - On acceptance of the last sample: base += HOP, rd_off=0, frame_idx increments (wraps at 2^FIDX_W).
- Write and read in the same cycle are allowed.
  - The occupancy used for in_ready reflects the registered base. A base advance on that cycle takes effect the next cycle.
  - No sample still needed by the current frame is ever overwritten (guaranteed by depth 2*FRAME_LEN).
- Frame count:
  - If NUM_FRAMES>0, acceptance of the last sample of frame NUM_FRAMES-1 pulses fefinish the next cycle, clears busy and returns to IDLE. Samples remaining in the buffer are discarded.
  - If NUM_FRAMES=0, fefinish never asserts.
- Stall on input: the frame in progress continues only while data is present. The block never emits a sample not yet written.

Test Plan:
- FRAME_LEN=8, HOP=4, NUM_FRAMES=3, fs_control=1. Stream samples 0..19 with out_ready=1 -> frames {0..7}, {4..11}, {8..15}; out_last on 7/11/15; frame_idx 0,1,2; fefinish one cycle after sample 15 accepted; busy=0 after.
- Same configuration with fs_control=0, stream 0..39 -> frames {0,2,..,14}, {8,..,22}, {16,..,30}.
- out_ready held 0 with in_valid=1 continuously -> in_ready deasserts exactly when 16 samples are stored; out_data stays 0 and stable. Releasing out_ready resumes with no loss and no duplication.
- HOP=FRAME_LEN=8, random in_valid/out_ready gaps (50%) -> non-overlapping frames 0..7, 8..15 match the scoreboard exactly.
- Assert rst_n=0 mid-frame (rd_off=3), then start -> all outputs return to their reset values asynchronously; after start, the first frame starts with the first new sample.
- start pulse mid-run -> out_valid low next cycle; frame_idx restarts at 0; old samples never appear at the output.

Source files
------------

// File: rtl/mfcc_framer.sv
// Framing stage for the MFCC front end.
// Buffers a valid/ready sample stream (optionally decimated by 2) in a
// circular buffer of 2*FRAME_LEN entries and replays overlapping frames of
// FRAME_LEN samples, advancing HOP samples per frame.
//
// state  | meaning
// S_IDLE | no run active, input not accepted, output quiet
// S_RUN  | accepting samples and emitting frames
module mfcc_framer #(
  parameter int DATA_W     = 16,
  parameter int FRAME_LEN  = 256,
  parameter int HOP        = 128,
  parameter int NUM_FRAMES = 0,
  parameter int FIDX_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              fs_control,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [FIDX_W-1:0] frame_idx,
  output logic              fefinish,
  output logic              busy
);

  localparam int DEPTH = 2 * FRAME_LEN;
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int OFF_W = $clog2(FRAME_LEN) + 1;

  localparam logic [PTR_W-1:0]  DEPTH_P   = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0]  FLEN_P    = PTR_W'(FRAME_LEN);
  localparam logic [PTR_W-1:0]  HOP_P     = PTR_W'(HOP);
  localparam logic [OFF_W-1:0]  FLEN_O    = OFF_W'(FRAME_LEN);
  localparam logic [OFF_W-1:0]  LAST_O    = OFF_W'(FRAME_LEN - 1);
  localparam logic [FIDX_W-1:0] LAST_FIDX = FIDX_W'(NUM_FRAMES - 1);
  localparam bit                COUNTED   = (NUM_FRAMES > 0);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  base;
  logic [OFF_W-1:0]  rd_off;   // samples of the current frame already loaded
  logic              mode_full;
  logic              phase;

  logic [PTR_W-1:0]  occ;
  logic [PTR_W-1:0]  cur_base;
  logic [PTR_W-1:0]  occ_cur;
  logic [AW-1:0]     rd_addr;
  logic [OFF_W-1:0]  cur_off;
  logic              in_xfer;
  logic              wr_en;
  logic              out_acc;
  logic              acc_last;
  logic              finish;
  logic              load;

  // Occupancy against the registered base; a base advance shows up next cycle.
  assign occ      = wr_ptr - base;
  assign in_ready = (state == S_RUN) && (occ < DEPTH_P);

  // Handshake decode and next-sample selection. When the last sample of a
  // frame is accepted, the loader already looks at the next frame so the
  // output keeps running at one sample per clock.
  always_comb begin
    in_xfer  = in_valid && in_ready && !start;
    wr_en    = in_xfer && (mode_full || !phase);
    out_acc  = out_valid && out_ready;
    acc_last = out_acc && out_last;
    finish   = COUNTED && acc_last && (frame_idx == LAST_FIDX);
    cur_base = acc_last ? (base + HOP_P) : base;
    cur_off  = acc_last ? '0 : rd_off;
    occ_cur  = wr_ptr - cur_base;
    rd_addr  = AW'(cur_base + PTR_W'(cur_off));
    load     = (state == S_RUN) && !start && !finish &&
               (!out_valid || out_ready) &&
               (cur_off < FLEN_O) && (occ_cur >= FLEN_P);
  end

  // Sample storage; no reset needed since pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

  // Run control, pointers and registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      base      <= '0;
      rd_off    <= '0;
      mode_full <= 1'b1;
      phase     <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_idx <= '0;
      fefinish  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      fefinish <= 1'b0;
      if (start) begin
        state     <= S_RUN;
        wr_ptr    <= '0;
        base      <= '0;
        rd_off    <= '0;
        mode_full <= fs_control;
        phase     <= 1'b0;
        out_data  <= '0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        frame_idx <= '0;
        busy      <= 1'b1;
      end else if (state == S_RUN) begin
        if (in_xfer) begin
          phase <= mode_full ? 1'b0 : ~phase;
          if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
          end
        end
        if (acc_last) begin
          base      <= base + HOP_P;
          frame_idx <= frame_idx + 1'b1;
        end
        if (finish) begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          fefinish  <= 1'b1;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          rd_off    <= '0;
        end else if (load) begin
          out_data  <= mem[rd_addr];
          out_valid <= 1'b1;
          out_last  <= (cur_off == LAST_O);
          rd_off    <= cur_off + 1'b1;
        end else begin
          if (out_acc) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
          rd_off <= cur_off;
        end
      end
    end
  end

endmodule
